// File: rtl/cpu_reg_pkg.sv
// -----------------------------------------------------------------------------
// cpu_reg_pkg
//   Types and defaults shared by the CPU register file and the reg_xfer_ctrl
//   command initiator.
//   - op_e           : transfer command opcodes
//   - xfer_state_e   : reg_xfer_ctrl sequencing states
//   - DEF_DATA_W/ADDR_W : register width and select width of the file
// -----------------------------------------------------------------------------
package cpu_reg_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 3;

   typedef enum logic [1:0] {
      OP_MOV  = 2'd0,
      OP_LDI  = 2'd1,
      OP_RD   = 2'd2,
      OP_SWAP = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD_A = 3'd1,
      ST_RD_B = 3'd2,
      ST_WR_A = 3'd3,
      ST_WR_B = 3'd4,
      ST_RESP = 3'd5
   } xfer_state_e;

endpackage : cpu_reg_pkg

// File: rtl/reg_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// reg_xfer_ctrl
//   Command-driven master for the register file's read port (sel_out /
//   output_enable / data_out) and write port (sel_in / data_in /
//   enable_write). Executes MOV, LDI, RD and SWAP one port access per cycle
//   and returns RD data over a valid/ready response channel.
//
// Ports
//   clk, rst_n                    clock, async active-low reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_op/cmd_a/cmd_b/cmd_imm    command fields, latched on accept
//   rsp_valid/rsp_ready/rsp_data  read-back response handshake
//   op_done                       one-cycle pulse after a command retires
//   rf_sel_in/rf_data_in/rf_enable_write    register file write port
//   rf_sel_out/rf_output_enable/rf_data_out register file read port
// -----------------------------------------------------------------------------
module reg_xfer_ctrl
   import cpu_reg_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_a,
   input  logic [ADDR_W-1:0] cmd_b,
   input  logic [DATA_W-1:0] cmd_imm,

   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,

   output logic              op_done,

   output logic [ADDR_W-1:0] rf_sel_in,
   output logic [DATA_W-1:0] rf_data_in,
   output logic              rf_enable_write,
   output logic [ADDR_W-1:0] rf_sel_out,
   output logic              rf_output_enable,
   input  logic [DATA_W-1:0] rf_data_out
);

   xfer_state_e       r_state;
   xfer_state_e       w_state_nxt;
   op_e               r_op;
   logic [ADDR_W-1:0] r_a;
   logic [ADDR_W-1:0] r_b;
   logic [DATA_W-1:0] r_imm;
   logic [DATA_W-1:0] r_cap_a;
   logic [DATA_W-1:0] r_cap_b;
   logic              r_op_done;

   logic              w_accept;
   logic              w_retire;

   // Gating with rst_n keeps the handshake closed while reset is held,
   // even though the state register already reads IDLE.
   assign cmd_ready = rst_n && (r_state == ST_IDLE);
   assign w_accept  = cmd_valid && cmd_ready;

   assign rsp_valid = (r_state == ST_RESP);
   assign rsp_data  = r_cap_a;
   assign op_done   = r_op_done;

   // State register, latched command and capture registers.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_op      <= OP_MOV;
         r_a       <= '0;
         r_b       <= '0;
         r_imm     <= '0;
         r_cap_a   <= '0;
         r_cap_b   <= '0;
         r_op_done <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_op_done <= w_retire;
         if (w_accept) begin
            r_op  <= op_e'(cmd_op);
            r_a   <= cmd_a;
            r_b   <= cmd_b;
            r_imm <= cmd_imm;
         end
         if (r_state == ST_RD_A) r_cap_a <= rf_data_out;
         if (r_state == ST_RD_B) r_cap_b <= rf_data_out;
      end
   end

   // Next state and port decode. The rf_* ports depend only on the state
   // register and latched fields, so no cmd_* input reaches them
   // combinationally, and an async reset drops every strobe at once.
   // NOTE: every signal gets a default before the case so no path through
   // this block can infer a latch.
   always_comb begin
      w_state_nxt      = r_state;
      w_retire         = 1'b0;
      rf_sel_in        = '0;
      rf_data_in       = '0;
      rf_enable_write  = 1'b0;
      rf_sel_out       = '0;
      rf_output_enable = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = (op_e'(cmd_op) == OP_LDI) ? ST_WR_A : ST_RD_A;
            end
         end

         ST_RD_A: begin
            rf_output_enable = 1'b1;
            // MOV reads its source (b); RD and SWAP read a first.
            rf_sel_out = (r_op == OP_MOV) ? r_b : r_a;
            case (r_op)
               OP_RD:   w_state_nxt = ST_RESP;
               OP_SWAP: w_state_nxt = ST_RD_B;
               default: w_state_nxt = ST_WR_A;
            endcase
         end

         ST_RD_B: begin
            rf_output_enable = 1'b1;
            rf_sel_out       = r_b;
            w_state_nxt      = ST_WR_A;
         end

         ST_WR_A: begin
            rf_enable_write = 1'b1;
            rf_sel_in       = r_a;
            case (r_op)
               OP_LDI:  rf_data_in = r_imm;
               OP_SWAP: rf_data_in = r_cap_b;
               default: rf_data_in = r_cap_a;
            endcase
            if (r_op == OP_SWAP) begin
               w_state_nxt = ST_WR_B;
            end else begin
               w_state_nxt = ST_IDLE;
               w_retire    = 1'b1;
            end
         end

         ST_WR_B: begin
            rf_enable_write = 1'b1;
            rf_sel_in       = r_b;
            rf_data_in      = r_cap_a;
            w_state_nxt     = ST_IDLE;
            w_retire        = 1'b1;
         end

         ST_RESP: begin
            if (rsp_ready) begin
               w_state_nxt = ST_IDLE;
               w_retire    = 1'b1;
            end
         end

         default: w_state_nxt = ST_IDLE;
      endcase
   end

endmodule : reg_xfer_ctrl

// File: tb/tb_reg_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_xfer_ctrl
//   Directed bench for reg_xfer_ctrl attached to a behavioural model of the
//   CPU register file (combinational read, write on the rising edge).
//   Inputs are driven and outputs sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_reg_xfer_ctrl;
   import cpu_reg_pkg::*;

   localparam int DW = DEF_DATA_W;
   localparam int AW = DEF_ADDR_W;

   logic          clk;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [AW-1:0] cmd_a;
   logic [AW-1:0] cmd_b;
   logic [DW-1:0] cmd_imm;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic          op_done;
   logic [AW-1:0] rf_sel_in;
   logic [DW-1:0] rf_data_in;
   logic          rf_enable_write;
   logic [AW-1:0] rf_sel_out;
   logic          rf_output_enable;
   logic [DW-1:0] rf_data_out;

   logic [DW-1:0] rf_mem [2**AW];

   int n_checks;
   int n_errors;
   int n_acc;
   int n_wr;

   reg_xfer_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_op           (cmd_op),
      .cmd_a            (cmd_a),
      .cmd_b            (cmd_b),
      .cmd_imm          (cmd_imm),
      .rsp_valid        (rsp_valid),
      .rsp_ready        (rsp_ready),
      .rsp_data         (rsp_data),
      .op_done          (op_done),
      .rf_sel_in        (rf_sel_in),
      .rf_data_in       (rf_data_in),
      .rf_enable_write  (rf_enable_write),
      .rf_sel_out       (rf_sel_out),
      .rf_output_enable (rf_output_enable),
      .rf_data_out      (rf_data_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file model: no reset on the storage, contents set up by the
   // bench's initial block.
   assign rf_data_out = rf_mem[rf_sel_out];
   always @(posedge clk) begin
      if (rf_enable_write) rf_mem[rf_sel_in] <= rf_data_in;
   end

   // Accept and write counters for the no-loss / no-duplicate check.
   always @(posedge clk) begin
      if (cmd_valid && cmd_ready) n_acc <= n_acc + 1;
      if (rf_enable_write)        n_wr  <= n_wr + 1;
   end

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present a command, wait (bounded) for cmd_ready, and return one time
   // unit after the accepting edge with cmd_valid dropped.
   task automatic send_cmd(input op_e op, input logic [AW-1:0] a,
                           input logic [AW-1:0] b, input logic [DW-1:0] imm);
      int waited;
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_a     = a;
      cmd_b     = b;
      cmd_imm   = imm;
      waited    = 0;
      while (!cmd_ready && waited < 20) begin
         step();
         waited++;
      end
      check("cmd_ready_timeout", 16'(waited < 20), 16'd1);
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic do_ldi(input logic [AW-1:0] a, input logic [DW-1:0] imm);
      send_cmd(OP_LDI, a, '0, imm);
      step();
   endtask

   initial begin
      int acc0;
      int wr0;
      n_checks  = 0;
      n_errors  = 0;
      n_acc     = 0;
      n_wr      = 0;
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = '0;
      cmd_a     = '0;
      cmd_b     = '0;
      cmd_imm   = '0;
      rsp_ready = 1'b0;
      for (int i = 0; i < 2**AW; i++) rf_mem[i] = '0;

      // ---- reset state ----
      step();
      step();
      check("rst_cmd_ready", 16'(cmd_ready),       16'd0);
      check("rst_we",        16'(rf_enable_write), 16'd0);
      check("rst_oe",        16'(rf_output_enable),16'd0);
      check("rst_rsp_valid", 16'(rsp_valid),       16'd0);
      check("rst_op_done",   16'(op_done),         16'd0);
      check("rst_sel_in",    16'(rf_sel_in),       16'd0);
      check("rst_rsp_data",  16'(rsp_data),        16'd0);
      rst_n = 1'b1;
      step();
      check("idle_cmd_ready", 16'(cmd_ready), 16'd1);

      // ---- LDI r2 = 0x5A ----
      send_cmd(OP_LDI, 3'd2, 3'd0, 8'h5A);
      check("ldi_we",        16'(rf_enable_write), 16'd1);
      check("ldi_sel_in",    16'(rf_sel_in),       16'd2);
      check("ldi_data_in",   16'(rf_data_in),      16'h5A);
      check("ldi_busy",      16'(cmd_ready),       16'd0);
      step();
      check("ldi_done",      16'(op_done),         16'd1);
      check("ldi_we_off",    16'(rf_enable_write), 16'd0);
      check("ldi_r2",        16'(rf_mem[2]),       16'h5A);
      check("ldi_ready",     16'(cmd_ready),       16'd1);
      step();
      check("ldi_done_pulse",16'(op_done),         16'd0);

      // ---- MOV r3 <= r1 ----
      do_ldi(3'd0, 8'h11);
      do_ldi(3'd1, 8'h22);
      send_cmd(OP_MOV, 3'd3, 3'd1, 8'h00);
      check("mov_oe",        16'(rf_output_enable),16'd1);
      check("mov_sel_out",   16'(rf_sel_out),      16'd1);
      check("mov_rd_we",     16'(rf_enable_write), 16'd0);
      check("mov_busy1",     16'(cmd_ready),       16'd0);
      step();
      check("mov_we",        16'(rf_enable_write), 16'd1);
      check("mov_sel_in",    16'(rf_sel_in),       16'd3);
      check("mov_data_in",   16'(rf_data_in),      16'h22);
      check("mov_busy2",     16'(cmd_ready),       16'd0);
      step();
      check("mov_ready",     16'(cmd_ready),       16'd1);
      check("mov_done",      16'(op_done),         16'd1);
      check("mov_r3",        16'(rf_mem[3]),       16'h22);

      // ---- SWAP r0 <-> r1 ----
      send_cmd(OP_SWAP, 3'd0, 3'd1, 8'h00);
      check("swp_sel_a",     16'(rf_sel_out),      16'd0);
      check("swp_oe_a",      16'(rf_output_enable),16'd1);
      step();
      check("swp_sel_b",     16'(rf_sel_out),      16'd1);
      check("swp_busy2",     16'(cmd_ready),       16'd0);
      step();
      check("swp_wa_sel",    16'(rf_sel_in),       16'd0);
      check("swp_wa_data",   16'(rf_data_in),      16'h22);
      check("swp_wa_done",   16'(op_done),         16'd0);
      step();
      check("swp_wb_sel",    16'(rf_sel_in),       16'd1);
      check("swp_wb_data",   16'(rf_data_in),      16'h11);
      check("swp_busy4",     16'(cmd_ready),       16'd0);
      step();
      check("swp_done",      16'(op_done),         16'd1);
      check("swp_r0",        16'(rf_mem[0]),       16'h22);
      check("swp_r1",        16'(rf_mem[1]),       16'h11);

      // ---- MOV / SWAP with a == b leave the register unchanged ----
      send_cmd(OP_MOV, 3'd2, 3'd2, 8'h00);
      step();
      step();
      check("mov_same_r2",   16'(rf_mem[2]),       16'h5A);
      send_cmd(OP_SWAP, 3'd3, 3'd3, 8'h00);
      repeat (4) step();
      check("swp_same_done", 16'(op_done),         16'd1);
      check("swp_same_r3",   16'(rf_mem[3]),       16'h22);

      // ---- RD r3 with rsp_ready held low for 5 cycles ----
      send_cmd(OP_RD, 3'd3, 3'd0, 8'h00);
      check("rd_sel_out",    16'(rf_sel_out),      16'd3);
      step();
      for (int i = 0; i < 5; i++) begin
         check("rd_hold_valid", 16'(rsp_valid),  16'd1);
         check("rd_hold_data",  16'(rsp_data),   16'h22);
         check("rd_hold_done",  16'(op_done),    16'd0);
         check("rd_hold_busy",  16'(cmd_ready),  16'd0);
         step();
      end
      rsp_ready = 1'b1;
      check("rd_hs_valid",   16'(rsp_valid),       16'd1);
      step();
      rsp_ready = 1'b0;
      check("rd_ret_valid",  16'(rsp_valid),       16'd0);
      check("rd_ret_done",   16'(op_done),         16'd1);
      step();
      check("rd_done_once",  16'(op_done),         16'd0);

      // ---- RD r0 with rsp_ready already high: one-cycle RESP ----
      rsp_ready = 1'b1;
      send_cmd(OP_RD, 3'd0, 3'd0, 8'h00);
      step();
      check("rd1_valid",     16'(rsp_valid),       16'd1);
      check("rd1_data",      16'(rsp_data),        16'h22);
      step();
      check("rd1_done",      16'(op_done),         16'd1);
      check("rd1_ready",     16'(cmd_ready),       16'd1);
      rsp_ready = 1'b0;

      // ---- back-to-back LDIs with cmd_valid held high ----
      acc0 = n_acc;
      wr0  = n_wr;
      cmd_valid = 1'b1;
      cmd_op    = OP_LDI;
      for (int i = 0; i < 4; i++) begin
         cmd_a   = AW'(4 + i);
         cmd_imm = DW'(8'hA0 + i);
         check("b2b_ready", 16'(cmd_ready), 16'd1);
         step();
         check("b2b_busy",  16'(cmd_ready), 16'd0);
         step();
      end
      cmd_valid = 1'b0;
      step();
      check("b2b_accepts",   16'(n_acc - acc0),    16'd4);
      check("b2b_writes",    16'(n_wr - wr0),      16'd4);
      check("b2b_r4",        16'(rf_mem[4]),       16'hA0);
      check("b2b_r5",        16'(rf_mem[5]),       16'hA1);
      check("b2b_r6",        16'(rf_mem[6]),       16'hA2);
      check("b2b_r7",        16'(rf_mem[7]),       16'hA3);

      // ---- reset during WR_A of SWAP r0 <-> r1 (r0=0x22, r1=0x11) ----
      send_cmd(OP_SWAP, 3'd0, 3'd1, 8'h00);
      step();
      step();
      check("rst_mid_in_wr", 16'(rf_enable_write), 16'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_mid_we",    16'(rf_enable_write), 16'd0);
      check("rst_mid_ready", 16'(cmd_ready),       16'd0);
      check("rst_mid_rsp",   16'(rsp_valid),       16'd0);
      step();
      check("rst_mid_r0",    16'(rf_mem[0]),       16'h22);
      check("rst_mid_r1",    16'(rf_mem[1]),       16'h11);
      rst_n = 1'b1;
      step();
      check("rst_mid_idle",  16'(cmd_ready),       16'd1);
      check("rst_mid_done",  16'(op_done),         16'd0);

      // ---- reset while a response is pending discards it ----
      send_cmd(OP_RD, 3'd5, 3'd0, 8'h00);
      step();
      check("rst_rsp_pend",  16'(rsp_valid),       16'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_rsp_drop",  16'(rsp_valid),       16'd0);
      step();
      rst_n = 1'b1;
      step();
      step();
      check("rst_rsp_gone",  16'(rsp_valid),       16'd0);
      check("rst_rsp_idle",  16'(cmd_ready),       16'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_reg_xfer_ctrl

// File: doc/reg_xfer_ctrl.md
Name: reg_xfer_ctrl

Overview:
- Command-driven initiator that sits on the master side of the CPU register file's write/read port pair.
- Accepts register-transfer commands (move, load-immediate, read-back, swap) over a valid/ready channel.
- Sequences the file's sel_out/output_enable read port and sel_in/enable_write write port, cycle by cycle.
- Returns read-back data over a response handshake. It lets the control unit or debug logic perform transfers without hand-driving the port pair.

Parameters:
- DATA_W, 8, register data width.
- ADDR_W, 3, register select width (2**ADDR_W registers).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  opcode: 0 MOV, 1 LDI, 2 RD, 3 SWAP.
- cmd_a  in  ADDR_W  destination (MOV/LDI), source (RD), first register (SWAP).
- cmd_b  in  ADDR_W  source (MOV), second register (SWAP); ignored otherwise.
- cmd_imm  in  DATA_W  immediate for LDI.
- rsp_valid  out  1  read-back data valid (RD only).
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  DATA_W  read-back value.
- op_done  out  1  one-cycle pulse when a command retires.
- rf_sel_in  out  ADDR_W  register file write select.
- rf_data_in  out  DATA_W  register file write data.
- rf_enable_write  out  1  register file write strobe.
- rf_sel_out  out  ADDR_W  register file read select.
- rf_output_enable  out  1  register file read enable.
- rf_data_out  in  DATA_W  register file read data; combinational from rf_sel_out.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - state IDLE; latched command fields 0; capture registers A and B 0.
  - rsp_valid 0, op_done 0, rf_enable_write 0, rf_output_enable 0, all rf_* buses 0.
  - cmd_ready is forced 0 while rst_n is low.
- FSM states: IDLE, RD_A, RD_B, WR_A, WR_B, RESP.
- cmd_ready = (state == IDLE). A command is accepted on a rising edge with cmd_valid && cmd_ready, and the op, a, b and imm fields are latched at that edge.
- Command sequences after accept:
  - MOV: RD_A (read cmd_b) -> WR_A (write cmd_a with captured A) -> IDLE. Two busy cycles.
  - LDI: WR_A (write cmd_a with imm) -> IDLE. One busy cycle.
  - RD: RD_A (read cmd_a) -> RESP. Stays in RESP until rsp_ready; the cycle with rsp_valid && rsp_ready retires the command -> IDLE.
  - SWAP: RD_A (read a) -> RD_B (read b) -> WR_A (a <= captured B) -> WR_B (b <= captured A) -> IDLE. Four busy cycles.
- Read states: rf_output_enable = 1 and rf_sel_out = target register. rf_data_out is sampled into capture A (RD_A) or capture B (RD_B) at the edge ending the state.
- Write states: rf_enable_write = 1 and rf_sel_in / rf_data_in are valid for exactly that cycle. The register file updates at the edge ending the state.
- rf_* outputs decode only from the state register and latched fields. There is no combinational path from cmd_* to rf_*.
- rsp_data holds captured A; rsp_valid = (state == RESP). rsp_data must be stable while rsp_valid is high and rsp_ready is low.
- op_done is a registered pulse, high for the one cycle after retirement: after WR_A for MOV/LDI, after WR_B for SWAP, after the RESP handshake for RD.
- Earliest next accept is the cycle after retirement, i.e. when state is back in IDLE.
- Boundary conditions:
  - MOV or SWAP with a == b: full sequence runs, register value unchanged.
  - rsp_ready already high on entry to RESP: one-cycle RESP.
  - Reset mid-sequence: immediate return to IDLE, all strobes drop asynchronously, no partial write is completed, and any pending response is discarded.
  - cmd_valid while busy: ignored; cmd_ready stays low.
- Widths: no arithmetic. Data passes through unmodified at DATA_W; addresses at ADDR_W.

Decomposition:
- Package cpu_reg_pkg holds:
  - op enum (OP_MOV=0, OP_LDI=1, OP_RD=2, OP_SWAP=3);
  - FSM state enum;
  - default DATA_W/ADDR_W localparams shared with the register file.
- No sub-module; the FSM and capture registers are a single module.
- The bench instantiates this block together with the existing register file.

Test Plan:
- Reset, then LDI a=2 imm=0x5A -> one rf_enable_write cycle with rf_sel_in=2, rf_data_in=0x5A; op_done pulses; register 2 = 0x5A.
- After LDI r0=0x11 and r1=0x22, MOV a=3 b=1 -> read of sel_out=1, then write of r3=0x22; exactly 2 busy cycles; cmd_ready low throughout.
- SWAP a=0 b=1 (r0=0x11, r1=0x22) -> 4 busy cycles; afterwards r0=0x22, r1=0x11.
- RD a=3 with rsp_ready held low for 5 cycles -> rsp_valid high and rsp_data=0x22 stable for all 5 cycles; retires on the cycle rsp_ready goes high; op_done pulses once.
- cmd_valid held high with back-to-back LDIs -> one accept per 2 cycles; no command is lost or duplicated.
- rst_n asserted during the WR_A state of a SWAP -> rf_enable_write drops immediately; r1 is untouched; state IDLE; rsp_valid 0.
